// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake between the UART receive FIFO (master) and its consumer (slave).
// A pop happens on any cycle where rd_valid && rd_ready.
interface uart_rx_fifo_if;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky overflow/framing flags.
// A byte appears on rd_data one cycle after its stop sample; when the FIFO is full, new bytes are dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  uart_rx_fifo_if.master              rd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err,
  input  logic                        err_clear
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, ovf_set, fe_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [AW-1:0] last_idx;
  logic          empty, full, pop;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // The bit counter restarts on every state entry and after every sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
            if (full && !pop) ovf_set = 1'b1;
            else              push    = 1'b1;
          end else begin
            fe_set  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = rd.rd_valid && rd.rd_ready;
  assign fifo_count = wptr_q - rptr_q;
  assign last_idx   = wptr_q[AW-1:0] - 1'b1;

  // When empty, show the most recently written byte so rd_data never goes X.
  assign rd.rd_valid = !empty;
  assign rd.rd_data  = empty ? mem[last_idx] : mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        mem[wptr_q[AW-1:0]] <= shift_q;
        wptr_q              <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~err_clear);
      frame_err <= fe_set | (frame_err & ~err_clear);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames queue their expected bytes, a negedge monitor checks every pop.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       err_clear;
  logic [2:0] fifo_count;
  logic       overflow, frame_err;

  uart_rx_fifo_if rd();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd(rd),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;
  int last_k = -1000;
  int max_count = 0;
  bit chk_en = 1'b1;
  bit auto_pop = 1'b0, manual_pop = 1'b0, pop_on_stop = 1'b0;
  bit manual_clr = 1'b0, clr_on_stop = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  // Consumer side: ready/clear driven just after each rising edge. Stop sample of a frame started at k is cycle k+154.
  always @(posedge clk) begin
    #1;
    rd.rd_ready = manual_pop || (auto_pop && rd.rd_valid) || (pop_on_stop && cyc == last_k + 154);
    err_clear   = manual_clr || (clr_on_stop && cyc == last_k + 154);
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (rd.rd_valid && rd.rd_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL pop_unexpected got=%0h required=none", rd.rd_data);
        end else begin
          check("pop_data", {24'd0, rd.rd_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_push);
    @(posedge clk); #1;
    last_k = cyc;
    if (expect_push) exp_q.push_back(b);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    int n;
    n = 0;
    @(negedge clk);
    while (!rd.rd_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rd.rd_valid) begin
      tests++;
      failed++;
      $display("FAIL pop_timeout rd_valid=0 required=1");
    end else begin
      manual_pop = 1'b1;
      @(negedge clk);
      manual_pop = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    manual_clr = 1'b1;
    @(negedge clk);
    manual_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rise_cyc;

    // 1: reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rd.rd_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_valid", rd.rd_valid, 0);
    check("idle_count", fifo_count, 0);
    check("idle_ovf", overflow, 0);
    check("idle_ferr", frame_err, 0);

    // 2: single byte with latency
    rise_cyc = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        for (int n = 0; n < 300 && rise_cyc < 0; n++) begin
          @(negedge clk);
          if (rd.rd_valid) rise_cyc = cyc;
        end
      end
    join
    check("a5_latency", rise_cyc, last_k + 155);
    check("a5_head", rd.rd_data, 8'hA5);
    check("a5_count", fifo_count, 1);
    pop_one();
    check("a5_valid_after_pop", rd.rd_valid, 0);
    check("a5_count_after_pop", fifo_count, 0);
    check("a5_data_stable", rd.rd_data, 8'hA5);

    // 3: glitch, framing error with long break, recovery
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr", frame_err, 0);
    clr_on_stop = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0);
    clr_on_stop = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("ferr_set_wins", frame_err, 1);
    check("ferr_count", fifo_count, 0);
    pulse_clear();
    repeat (50) @(negedge clk);
    check("break_single_event", frame_err, 0);
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h11, 1'b1, 1'b1);
    @(negedge clk);
    check("recover_head", rd.rd_data, 8'h11);
    check("recover_ferr", frame_err, 0);
    pop_one();

    // 4: fill and overflow
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
    @(negedge clk);
    check("fill_count", fifo_count, 4);
    check("fill_ovf", overflow, 0);
    send_frame(8'h05, 1'b1, 1'b0);
    @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) pop_one();
    check("drained_valid", rd.rd_valid, 0);
    pulse_clear();
    check("ovf_cleared", overflow, 0);

    // 5: push and pop together at full, then streaming through the wrap
    max_count = 0;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
    pop_on_stop = 1'b1;
    send_frame(8'h14, 1'b1, 1'b1);
    pop_on_stop = 1'b0;
    @(negedge clk);
    check("full_pushpop_count", fifo_count, 4);
    check("full_pushpop_ovf", overflow, 0);
    auto_pop = 1'b1;
    for (int i = 5; i < 12; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    auto_pop = 1'b0;
    check("stream_all_received", exp_q.size(), 0);
    check("stream_ovf", overflow, 0);
    check("stream_max_le_depth", max_count <= DEPTH, 1);
    check("stream_count", fifo_count, 0);

    // 6: async reset in the middle of a frame
    send_frame(8'h3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h77, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_rst_count", fifo_count, 1);
    check("pre_rst_ferr", frame_err, 1);
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (70) @(posedge clk);
        #3;
        chk_en = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("arst_valid", rd.rd_valid, 0);
        check("arst_count", fifo_count, 0);
        check("arst_data", rd.rd_data, 0);
        check("arst_ferr", frame_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end
    join
    repeat (300) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) if (rd.rd_valid) pop_one();
    pulse_clear();
    chk_en = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    check("post_rst_head", rd.rd_data, 8'h5A);
    pop_one();
    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
